// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus master: FSM state encoding,
// peripheral register offsets and timer-control bit positions.
// Optional feature macro: PERIPH_BUS_IRQ_ACK_EN adds the interrupt
// acknowledge states ACK_RD/ACK_WR.
package periph_bus_pkg;

  localparam logic [31:0] OFF_TH     = 32'h0000_0000;
  localparam logic [31:0] OFF_TL     = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON   = 32'h0000_0008;
  localparam logic [31:0] OFF_LED    = 32'h0000_000C;
  localparam logic [31:0] OFF_SWITCH = 32'h0000_0010;
  localparam logic [31:0] OFF_DIGI   = 32'h0000_0014;

  // TCON bits: timer run, timer interrupt enable, timer overflow flag
  localparam int TCON_TR_BIT  = 0;
  localparam int TCON_TIE_BIT = 1;
  localparam int TCON_TF_BIT  = 2;

`ifdef PERIPH_BUS_IRQ_ACK_EN
  typedef enum logic [2:0] {IDLE, ACCESS, RESP, ACK_RD, ACK_WR} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif

  // Acknowledging the timer interrupt means writing TCON back with TF cleared
  function automatic logic [31:0] tcon_clear_tf(input logic [31:0] tcon);
    return tcon & ~(32'h1 << TCON_TF_BIT);
  endfunction

endpackage

// File: rtl/periph_bus_if.sv
// Command/response handshake plus peripheral strobe bus. The master modport
// is the bus-master block; the slave modport is whoever drives commands and
// models the peripheral.
interface periph_bus_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic        irq_ack;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, rdata, irq,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rd, wr, addr, wdata, irq_ack
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, rdata, irq,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rd, wr, addr, wdata, irq_ack
  );
endinterface

// File: rtl/periph_addr_decode.sv
// Combinational legality check for a peripheral address: inside the
// BASE_ADDR..LAST_ADDR window and word aligned.
module periph_addr_decode #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] LAST_ADDR = 32'h4000_0014
) (
  input  logic [31:0] addr,
  output logic        legal
);

  assign legal = (addr >= BASE_ADDR) && (addr <= LAST_ADDR) && (addr[1:0] == 2'b00);

endmodule

// File: rtl/periph_bus_master.sv
// Peripheral bus master: turns one command at a time into a single-cycle
// rd/wr strobe and returns a held response. All outputs are registered.
// Optional feature macro: PERIPH_BUS_IRQ_ACK_EN -- on a rising edge of irq
// the block reads TCON, clears TF, writes it back and pulses irq_ack.
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] LAST_ADDR = 32'h4000_0014
) (
  input  logic         clk,
  input  logic         reset,
  periph_bus_if.master bus
);

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        addr_legal;

  periph_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .LAST_ADDR (LAST_ADDR)
  ) u_addr_decode (
    .addr  (bus.cmd_addr),
    .legal (addr_legal)
  );

`ifdef PERIPH_BUS_IRQ_ACK_EN
  logic irq_q, irq_d;
  logic pending_q, pending_d;
  logic irq_ack_q, irq_ack_d;
  logic pend_clr;
  logic irq_rise;

  assign irq_rise    = bus.irq & ~irq_q;
  assign bus.irq_ack = irq_ack_q;
`else
  logic unused_irq;

  assign unused_irq  = bus.irq;
  assign bus.irq_ack = 1'b0;
`endif

  // Next-state and next-output computation; strobes and addr/wdata default to 0
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
`ifdef PERIPH_BUS_IRQ_ACK_EN
    irq_d       = bus.irq;
    irq_ack_d   = 1'b0;
    pend_clr    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // cmd_ready_q is already low whenever an interrupt is pending
        if (bus.cmd_valid && cmd_ready_q) begin
          if (addr_legal) begin
            state_d = ACCESS;
            rd_d    = ~bus.cmd_wr;
            wr_d    = bus.cmd_wr;
            addr_d  = bus.cmd_addr;
            wdata_d = bus.cmd_wr ? bus.cmd_wdata : '0;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
`ifdef PERIPH_BUS_IRQ_ACK_EN
        else if (pending_q) begin
          state_d = ACK_RD;
          rd_d    = 1'b1;
          addr_d  = BASE_ADDR + OFF_TCON;
        end
`endif
      end
      ACCESS: begin
        // rdata is combinational from the peripheral during the rd cycle
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rd_q ? bus.rdata : '0;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
`ifdef PERIPH_BUS_IRQ_ACK_EN
      ACK_RD: begin
        state_d   = ACK_WR;
        wr_d      = 1'b1;
        addr_d    = BASE_ADDR + OFF_TCON;
        wdata_d   = tcon_clear_tf(bus.rdata);
        irq_ack_d = 1'b1;
        pend_clr  = 1'b1;
      end
      ACK_WR: begin
        state_d = IDLE;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef PERIPH_BUS_IRQ_ACK_EN
    // A new edge wins over the clear so it is never lost
    pending_d   = (pending_q & ~pend_clr) | irq_rise;
    cmd_ready_d = (state_d == IDLE) && !pending_d;
`else
    cmd_ready_d = (state_d == IDLE);
`endif
  end

  // State and registered outputs; reset drops any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
`ifdef PERIPH_BUS_IRQ_ACK_EN
      irq_q       <= 1'b0;
      pending_q   <= 1'b0;
      irq_ack_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
`ifdef PERIPH_BUS_IRQ_ACK_EN
      irq_q       <= irq_d;
      pending_q   <= pending_d;
      irq_ack_q   <= irq_ack_d;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rd        = rd_q;
  assign bus.wr        = wr_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// Directed bench for periph_bus_master. Outputs are sampled 1 ns after each
// rising edge; inputs are changed at the same point. The peripheral returns
// rd_val while rd is high and all-ones otherwise.
module tb_periph_bus_master;

  logic        clk;
  logic        reset;
  logic [31:0] rd_val;
  int          n_checks;
  int          n_fail;
  logic [71:0] obs;
  logic [71:0] req;

  periph_bus_if bus ();

  periph_bus_master #(
    .BASE_ADDR (32'h4000_0000),
    .LAST_ADDR (32'h4000_0014)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.rdata = bus.rd ? rd_val : 32'hFFFF_FFFF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for exactly one edge
  task automatic offer(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.cmd_wr    = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    obs = {37'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    req = '0;
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL reset_rsp: got %h required %h", obs, req); end
    obs = {5'b0, bus.irq_ack, bus.rd, bus.wr, bus.addr, bus.wdata};
    req = '0;
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL reset_strobe: got %h required %h", obs, req); end
    reset = 1'b0;
    tick();
    obs = {37'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    req = {37'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL reset_release_ready: got %h required %h", obs, req); end
  endtask

  task automatic test_read();
    bus.rsp_ready = 1'b1;
    rd_val = 32'h0000_00A5;
    offer(1'b0, 32'h4000_0010, 32'hDEAD_BEEF);
    obs = {6'b0, bus.rd, bus.wr, bus.addr, bus.wdata};
    req = {6'b0, 1'b1, 1'b0, 32'h4000_0010, 32'h0};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL read_strobe: got %h required %h", obs, req); end
    obs = {37'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    req = '0;
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL read_no_early_rsp: got %h required %h", obs, req); end
    tick();
    obs = {6'b0, bus.rd, bus.wr, bus.addr, bus.wdata};
    req = '0;
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL read_strobe_one_cycle: got %h required %h", obs, req); end
    obs = {37'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    req = {37'b0, 1'b0, 1'b1, 1'b0, 32'h0000_00A5};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL read_rsp: got %h required %h", obs, req); end
    tick();
    obs = {37'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    req = {37'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL read_back_idle: got %h required %h", obs, req); end
  endtask

  task automatic test_write();
    bus.rsp_ready = 1'b1;
    rd_val = 32'h0000_0055;
    offer(1'b1, 32'h4000_000C, 32'h0000_003C);
    obs = {6'b0, bus.rd, bus.wr, bus.addr, bus.wdata};
    req = {6'b0, 1'b0, 1'b1, 32'h4000_000C, 32'h0000_003C};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL write_strobe: got %h required %h", obs, req); end
    tick();
    obs = {6'b0, bus.rd, bus.wr, bus.addr, bus.wdata};
    req = '0;
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL write_strobe_one_cycle: got %h required %h", obs, req); end
    obs = {37'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    req = {37'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL write_rsp: got %h required %h", obs, req); end
    tick();
  endtask

  // Illegal and boundary addresses; error responses come one cycle early
  task automatic test_addr_decode();
    logic [31:0] addrs [6];
    logic        legal [6];
    addrs = '{32'h4000_0018, 32'h4000_0002, 32'h3FFF_FFFC, 32'h4000_0000, 32'h4000_0014, 32'h4000_0016};
    legal = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bus.rsp_ready = 1'b1;
    rd_val = 32'h0000_0077;
    for (int i = 0; i < 6; i++) begin
      offer(1'b0, addrs[i], 32'h0);
      obs = {6'b0, bus.rd, bus.wr, bus.addr, bus.wdata};
      req = legal[i] ? {6'b0, 1'b1, 1'b0, addrs[i], 32'h0} : 72'h0;
      n_checks++;
      if (obs !== req) begin n_fail++; $display("FAIL decode_strobe[%0d]: got %h required %h", i, obs, req); end
      obs = {37'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
      req = legal[i] ? 72'h0 : {37'b0, 1'b0, 1'b1, 1'b1, 32'h0};
      n_checks++;
      if (obs !== req) begin n_fail++; $display("FAIL decode_rsp[%0d]: got %h required %h", i, obs, req); end
      tick();
      if (legal[i]) tick();
      obs = {37'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
      req = {37'b0, 1'b1, 1'b0, 1'b0, 32'h0};
      n_checks++;
      if (obs !== req) begin n_fail++; $display("FAIL decode_idle[%0d]: got %h required %h", i, obs, req); end
    end
  endtask

  task automatic test_rsp_hold();
    bus.rsp_ready = 1'b0;
    rd_val = 32'h1234_5678;
    offer(1'b0, 32'h4000_0004, 32'h0);
    tick();
    for (int i = 0; i < 6; i++) begin
      obs = {37'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
      req = {37'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678};
      n_checks++;
      if (obs !== req) begin n_fail++; $display("FAIL rsp_hold[%0d]: got %h required %h", i, obs, req); end
      rd_val = 32'hCAFE_0000 | i;
      if (i < 5) tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    obs = {37'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    req = {37'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL rsp_hold_release: got %h required %h", obs, req); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] rdy;
    bus.rsp_ready = 1'b1;
    rd_val = 32'h0000_0011;
    offer(1'b0, 32'h4000_0014, 32'h0);
    rdy[0] = bus.cmd_ready;
    tick();
    rdy[1] = bus.cmd_ready;
    tick();
    rdy[2] = bus.cmd_ready;
    obs = {69'b0, rdy};
    req = {69'b0, 3'b100};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL b2b_ready_spacing: got %h required %h", obs, req); end
    offer(1'b1, 32'h4000_0000, 32'h0000_0099);
    obs = {6'b0, bus.rd, bus.wr, bus.addr, bus.wdata};
    req = {6'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h0000_0099};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL b2b_second_strobe: got %h required %h", obs, req); end
    tick();
    tick();
  endtask

`ifdef PERIPH_BUS_IRQ_ACK_EN
  task automatic test_irq_ack();
    bus.rsp_ready = 1'b0;
    rd_val = 32'h0000_0007;
    offer(1'b1, 32'h4000_000C, 32'h0000_005A);
    tick();
    bus.irq = 1'b1;
    tick();
    obs = {37'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    req = {37'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL irq_rsp_held: got %h required %h", obs, req); end
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = 32'h4000_0010;
    bus.cmd_wdata = 32'h0;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    tick();
    obs = {37'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    req = '0;
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL irq_pending_blocks_cmd: got %h required %h", obs, req); end
    tick();
    obs = {5'b0, bus.irq_ack, bus.rd, bus.wr, bus.addr, bus.wdata};
    req = {5'b0, 1'b0, 1'b1, 1'b0, 32'h4000_0008, 32'h0};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL irq_ack_rd: got %h required %h", obs, req); end
    tick();
    obs = {5'b0, bus.irq_ack, bus.rd, bus.wr, bus.addr, bus.wdata};
    req = {5'b0, 1'b1, 1'b0, 1'b1, 32'h4000_0008, 32'h0000_0003};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL irq_ack_wr: got %h required %h", obs, req); end
    obs = {71'b0, bus.rsp_valid};
    req = '0;
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL irq_no_rsp: got %h required %h", obs, req); end
    tick();
    obs = {5'b0, bus.irq_ack, bus.rd, bus.wr, bus.addr, bus.wdata};
    req = '0;
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL irq_ack_one_cycle: got %h required %h", obs, req); end
    obs = {70'b0, bus.cmd_ready, bus.rsp_valid};
    req = {70'b0, 1'b1, 1'b0};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL irq_ready_after_ack: got %h required %h", obs, req); end
    tick();
    bus.cmd_valid = 1'b0;
    obs = {6'b0, bus.rd, bus.wr, bus.addr, bus.wdata};
    req = {6'b0, 1'b1, 1'b0, 32'h4000_0010, 32'h0};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL irq_waiting_cmd: got %h required %h", obs, req); end
    tick();
    obs = {37'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    req = {37'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0007};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL irq_waiting_rsp: got %h required %h", obs, req); end
    tick();
    bus.irq = 1'b0;
    tick();
  endtask
`else
  task automatic test_irq_ignored();
    bus.irq = 1'b1;
    tick();
    tick();
    obs = {5'b0, bus.irq_ack, bus.rd, bus.wr, bus.addr, bus.wdata};
    req = '0;
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL irq_ignored_strobe: got %h required %h", obs, req); end
    obs = {37'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    req = {37'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL irq_ignored_ready: got %h required %h", obs, req); end
    bus.irq = 1'b0;
    tick();
  endtask
`endif

  task automatic test_reset_in_access();
    bus.rsp_ready = 1'b1;
    rd_val = 32'h0000_00F0;
    offer(1'b0, 32'h4000_0008, 32'h0);
    obs = {6'b0, bus.rd, bus.wr, bus.addr, bus.wdata};
    req = {6'b0, 1'b1, 1'b0, 32'h4000_0008, 32'h0};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL rst_access_strobe: got %h required %h", obs, req); end
    reset = 1'b1;
    tick();
    obs = {2'b0, bus.irq_ack, bus.rd, bus.wr, bus.addr, bus.wdata, 3'b0};
    req = '0;
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL rst_access_strobe_clear: got %h required %h", obs, req); end
    obs = {37'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    req = '0;
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL rst_access_rsp_clear: got %h required %h", obs, req); end
    reset = 1'b0;
    tick();
    tick();
    obs = {37'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    req = {37'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    n_checks++;
    if (obs !== req) begin n_fail++; $display("FAIL rst_access_no_rsp: got %h required %h", obs, req); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    rd_val        = 32'h0;
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b1;
    bus.irq       = 1'b0;
    #1;
    test_reset();
    test_read();
    test_write();
    test_addr_decode();
    test_rsp_hold();
    test_back_to_back();
`ifdef PERIPH_BUS_IRQ_ACK_EN
    test_irq_ack();
`else
    test_irq_ignored();
`endif
    test_reset_in_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
